// File: rtl/shiftreg.sv
// ----------------------------------------------------------------------------
// shiftreg
//   Universal parallel-in/parallel-out shift register, WIDTH bits, one clock.
//   Each rising edge performs exactly one of four operations chosen by s:
//     00 hold, 01 shift right, 10 shift left, 11 parallel load.
//   Serves as a small data-staging / serialising element in the datapath.
//
// Build option
//   SHIFTREG_ROTATE_EN  defined   : modes 01/10 rotate q; a feeds only load.
//                       undefined : modes 01/10 fill from a[WIDTH-1] / a[0].
//
// Parameters
//   WIDTH   register width in bits (legal range WIDTH >= 2)
//
// Ports (positional order a, s, q, clk, reset)
//   a      in   WIDTH  parallel load data; a[WIDTH-1]/a[0] are serial fill bits
//   s      in   2      mode select
//   q      out  WIDTH  register contents, straight from flops
//   clk    in   1      clock, rising edge
//   reset  in   1      synchronous active-high reset, beats every mode
// ----------------------------------------------------------------------------
module shiftreg #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [1:0]       s,
    output logic [WIDTH-1:0] q,
    input  logic             clk,
    input  logic             reset
);

    typedef enum logic [1:0] {
        MODE_HOLD  = 2'b00,
        MODE_SHR   = 2'b01,
        MODE_SHL   = 2'b10,
        MODE_LOAD  = 2'b11
    } mode_e;

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic             fill_r;   // bit entering at the MSB on a right shift
    logic             fill_l;   // bit entering at the LSB on a left shift

`ifdef SHIFTREG_ROTATE_EN
    assign fill_r = q_q[0];
    assign fill_l = q_q[WIDTH-1];
`else
    assign fill_r = a[WIDTH-1];
    assign fill_l = a[0];
`endif

    // Unknown select values fall into default and hold, so a floating s never
    // corrupts the stored word.
    always_comb begin
        q_d = q_q;
        case (s)
            MODE_HOLD: q_d = q_q;
            MODE_SHR:  q_d = {fill_r, q_q[WIDTH-1:1]};
            MODE_SHL:  q_d = {q_q[WIDTH-2:0], fill_l};
            MODE_LOAD: q_d = a;
            default:   q_d = q_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: tb/tb_shiftreg.sv
// ----------------------------------------------------------------------------
// tb_shiftreg
//   Directed bench for shiftreg at WIDTH=4. Inputs change #1 after a rising
//   edge, the next edge captures them, and q is sampled #1 after that edge.
//   Expected words are hand-computed constants. Build with
//   +define+SHIFTREG_ROTATE_EN to exercise the rotate variant.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_shiftreg;

    localparam int WIDTH = 4;

    logic [WIDTH-1:0] a;
    logic [1:0]       s;
    logic [WIDTH-1:0] q;
    logic             clk;
    logic             reset;

    int n_chk  = 0;
    int n_pass = 0;

    shiftreg #(.WIDTH(WIDTH)) dut (
        .a     (a),
        .s     (s),
        .q     (q),
        .clk   (clk),
        .reset (reset)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [WIDTH-1:0] got,
                       input logic [WIDTH-1:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: q=%b expected %b", tag, got, exp);
    endtask

    // Apply inputs, let one rising edge capture them, sample q just after.
    task automatic step(input logic rst, input logic [1:0] mode,
                        input logic [WIDTH-1:0] din);
        reset = rst;
        s     = mode;
        a     = din;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        s     = 2'b00;
        a     = '0;
        @(posedge clk);
        #1;

        // 1: reset beats load
        step(1'b1, 2'b11, 4'b1101); chk("rst_over_load", q, 4'b0000);

`ifndef SHIFTREG_ROTATE_EN
        // 2: shift left filling from a[0]=1, then saturate
        step(1'b0, 2'b10, 4'b1101); chk("shl_fill_1", q, 4'b0001);
        step(1'b0, 2'b10, 4'b1101); chk("shl_fill_2", q, 4'b0011);
        step(1'b0, 2'b10, 4'b1101); chk("shl_fill_3", q, 4'b0111);
        step(1'b0, 2'b10, 4'b1101); chk("shl_fill_4", q, 4'b1111);
        step(1'b0, 2'b10, 4'b1101); chk("shl_sat",    q, 4'b1111);

        // 3: load, shift right filling from a[3]=1, hold three edges
        step(1'b0, 2'b11, 4'b1101); chk("load_1101", q, 4'b1101);
        step(1'b0, 2'b01, 4'b1101); chk("shr_fill1", q, 4'b1110);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 2'b00, 4'b0000); chk("hold", q, 4'b1110);
        end

        // 4: fill with zeros from a[3] and a[0]
        step(1'b0, 2'b11, 4'b1101); chk("load_1101b", q, 4'b1101);
        step(1'b0, 2'b01, 4'b0101); chk("shr_fill0",  q, 4'b0110);
        step(1'b0, 2'b10, 4'b0100); chk("shl_fill0",  q, 4'b1100);

        // 5: reset mid-shift discards it, then load resumes
        step(1'b0, 2'b11, 4'b1111); chk("load_1111", q, 4'b1111);
        step(1'b0, 2'b10, 4'b1101); chk("shl_mid",   q, 4'b1111);
        step(1'b1, 2'b10, 4'b1101); chk("rst_mid",   q, 4'b0000);
        step(1'b0, 2'b11, 4'b1010); chk("post_rst",  q, 4'b1010);

        // extra: shift right walking a pattern out, fill 0
        step(1'b0, 2'b01, 4'b0000); chk("shr_out_1", q, 4'b0101);
        step(1'b0, 2'b01, 4'b0000); chk("shr_out_2", q, 4'b0010);
        // reset also beats hold
        step(1'b1, 2'b00, 4'b1111); chk("rst_over_hold", q, 4'b0000);
`else
        // 6: rotate build
        step(1'b0, 2'b11, 4'b1101); chk("rot_load",  q, 4'b1101);
        step(1'b0, 2'b10, 4'b0000); chk("rotl_1",    q, 4'b1011);
        step(1'b0, 2'b10, 4'b0000); chk("rotl_2",    q, 4'b0111);
        step(1'b0, 2'b01, 4'b1111); chk("rotr_1",    q, 4'b1011);
        step(1'b0, 2'b01, 4'b0000); chk("rotr_2",    q, 4'b1101);
        step(1'b0, 2'b00, 4'b0000); chk("rot_hold",  q, 4'b1101);
        step(1'b0, 2'b11, 4'b1000); chk("rot_load2", q, 4'b1000);
        step(1'b0, 2'b10, 4'b0001); chk("rotl_wrap", q, 4'b0001);
        step(1'b0, 2'b01, 4'b1000); chk("rotr_wrap", q, 4'b1000);
        step(1'b0, 2'b01, 4'b0000); chk("rotr_3",    q, 4'b0100);
        step(1'b1, 2'b10, 4'b1111); chk("rot_rst",   q, 4'b0000);
        step(1'b0, 2'b11, 4'b1010); chk("rot_post",  q, 4'b1010);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: q=%b expected end of run", q);
        $fatal(1, "timeout");
    end

endmodule
